// File: rtl/ahb_lite_ram_slave.sv
// ahb_lite_ram_slave
//   Block-RAM AHB-Lite responder with a fixed, parameterised number of wait
//   states per OKAY data phase, a two-cycle ERROR response for misaligned or
//   oversized accesses, and write-to-read forwarding for back-to-back beats.
//
// Parameters
//   ADDR_BITS   word-address width (memory is 2^ADDR_BITS x 32)
//   WAIT_STATES HREADY-low cycles per OKAY data phase, 0..15
//
// Ports
//   HCLK, HRESETn         clock, synchronous active-low reset
//   HADDR, HSIZE, HTRANS  address-phase request (HBURST is ignored)
//   HSEL, HWRITE          slave select, write flag
//   HWDATA                write data, sampled at the edge that ends DATA
//   HRDATA                registered 32-bit read word, held between reads
//   HREADY, HRESP         transfer done / ERROR response
//   ACCCOUNT              count of completed OKAY transfers (wraps)
module ahb_lite_ram_slave #(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] HADDR,
    input  logic [2:0]  HBURST,
    input  logic        HSEL,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    input  logic        HWRITE,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output logic        HRESP,
    output logic [31:0] ACCCOUNT
);

    localparam int         DEPTH = 1 << ADDR_BITS;
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t                state_q, state_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [3:0]            lanes_q, lanes_d;
    logic                  write_q, write_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [31:0]           acc_q, acc_d;
    logic [31:0]           mem_q [DEPTH];

    logic                  accept;
    logic                  req_err;
    logic [3:0]            req_lanes;
    logic [ADDR_BITS-1:0]  req_addr;
    logic                  commit;
    logic                  rd_load;
    logic [31:0]           rd_word;

    // Upper address bits alias, HBURST and HTRANS[0] carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{HBURST, HTRANS[0], HADDR[31:ADDR_BITS+2]};

    assign HREADY   = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2);
    assign HRESP    = (state_q == S_ERR1) || (state_q == S_ERR2);
    assign HRDATA   = rdata_q;
    assign ACCCOUNT = acc_q;

    assign accept   = HREADY && HSEL && HTRANS[1];
    assign req_addr = HADDR[ADDR_BITS+1:2];
    assign commit   = (state_q == S_DATA) && write_q;

    // Byte-lane and alignment decode of the address phase.
    always_comb begin
        req_lanes = 4'b0000;
        req_err   = 1'b0;
        case (HSIZE)
            3'd0: req_lanes = 4'b0001 << HADDR[1:0];
            3'd1: begin
                req_lanes = HADDR[1] ? 4'b1100 : 4'b0011;
                req_err   = HADDR[0];
            end
            3'd2: begin
                req_lanes = 4'b1111;
                req_err   = |HADDR[1:0];
            end
            default: req_err = 1'b1;
        endcase
    end

    // Next-state logic. IDLE, DATA and ERR2 all drop back to IDLE unless a
    // new beat is accepted in the same cycle, which then overrides.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        lanes_d = lanes_q;
        write_d = write_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_DATA;
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase
        if (accept) begin
            addr_d  = req_addr;
            lanes_d = req_lanes;
            write_d = HWRITE;
            if (req_err) begin
                state_d = S_ERR1;
            end else if (WS != 4'd0) begin
                state_d = S_WAIT;
                cnt_d   = WS;
            end else begin
                state_d = S_DATA;
            end
        end
    end

    // HRDATA loads on any edge entering DATA for a read. addr_d/write_d name
    // the beat that will own DATA, whether it was just accepted or is leaving
    // WAIT. A write committing on that same edge to the same word is merged
    // in so a back-to-back read sees the new bytes.
    always_comb begin
        rd_load = (state_d == S_DATA) && !write_d;
        rd_word = mem_q[addr_d];
        if (commit && (addr_q == addr_d)) begin
            for (int b = 0; b < 4; b++) begin
                if (lanes_q[b]) rd_word[8*b +: 8] = HWDATA[8*b +: 8];
            end
        end
        rdata_d = rd_load ? rd_word : rdata_q;
        acc_d   = (state_q == S_DATA) ? acc_q + 32'd1 : acc_q;
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            lanes_q <= '0;
            write_q <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            lanes_q <= lanes_d;
            write_q <= write_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            acc_q   <= acc_d;
        end
    end

    // Memory is never cleared; reset only suppresses a write in flight.
    always_ff @(posedge HCLK) begin
        if (HRESETn && commit) begin
            for (int b = 0; b < 4; b++) begin
                if (lanes_q[b]) mem_q[addr_q][8*b +: 8] <= HWDATA[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ahb_lite_ram_slave.sv
module tb_ahb_lite_ram_slave;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] data;   // HWDATA for writes, expected HRDATA for reads
    } vec_t;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [31:0] HADDR, HWDATA;
    logic [2:0]  HBURST, HSIZE;
    logic        HSEL, HWRITE;
    logic [1:0]  HTRANS;

    logic [31:0] rdata0, rdata3, acc0, acc3;
    logic        rdy0, rdy3, resp0, resp3;
    bit          dsel;
    logic [31:0] rdata, acc;
    logic        rdy, resp;

    assign rdata = dsel ? rdata3 : rdata0;
    assign acc   = dsel ? acc3   : acc0;
    assign rdy   = dsel ? rdy3   : rdy0;
    assign resp  = dsel ? resp3  : resp0;

    always #5 HCLK = ~HCLK;

    ahb_lite_ram_slave #(.ADDR_BITS(10), .WAIT_STATES(0)) u_ws0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HBURST(HBURST),
        .HSEL(HSEL), .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA),
        .HWRITE(HWRITE), .HRDATA(rdata0), .HREADY(rdy0), .HRESP(resp0),
        .ACCCOUNT(acc0)
    );

    ahb_lite_ram_slave #(.ADDR_BITS(10), .WAIT_STATES(3)) u_ws3 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HBURST(HBURST),
        .HSEL(HSEL), .HSIZE(HSIZE), .HTRANS(HTRANS), .HWDATA(HWDATA),
        .HWRITE(HWRITE), .HRDATA(rdata3), .HREADY(rdy3), .HRESP(resp3),
        .ACCCOUNT(acc3)
    );

    int          total = 0;
    int          passed = 0;
    int          acc_exp = 0;
    vec_t        txq[$];
    logic [31:0] sbq[$];
    vec_t        tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic drive_addr(input bit v, input vec_t t);
        HSEL   = v;
        HTRANS = v ? 2'b10 : 2'b00;
        HADDR  = v ? t.addr : 32'h0;
        HSIZE  = v ? t.size : 3'd0;
        HWRITE = v ? t.wr : 1'b0;
    endtask

    task automatic do_reset(input int n);
        vec_t t;
        t = '{1'b0, 32'h0, 3'd0, 32'h0};
        HRESETn = 1'b0;
        drive_addr(1'b0, t);
        HWDATA = 32'h0;
        repeat (n) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        acc_exp = 0;
    endtask

    // Pipelined master: issues every queued beat back-to-back, pushes the
    // expected read word when a beat is driven and pops it when the beat's
    // data phase completes. Must be entered just after a rising edge.
    task automatic run_seq(input int ws, input string tag);
        vec_t        aph, dph;
        bit          aph_v, dph_v, adv;
        int          lows, nt, guard;
        logic [31:0] e;
        aph_v = 1'b0; dph_v = 1'b0; lows = 0; guard = 0;
        aph = '{1'b0, 32'h0, 3'd0, 32'h0};
        dph = aph;
        nt = txq.size();
        if (txq.size() > 0) begin
            aph = txq.pop_front(); aph_v = 1'b1;
            if (!aph.wr) sbq.push_back(aph.data);
        end
        drive_addr(aph_v, aph);
        while ((aph_v || dph_v) && guard < 1000) begin
            @(negedge HCLK);
            guard++;
            adv = rdy;
            if (!rdy) lows++;
            if (rdy && dph_v) begin
                acc_exp++;
                chk({tag, " hresp"}, 32'(resp), 32'h0);
                if (!dph.wr) begin
                    e = sbq.pop_front();
                    chk({tag, " hrdata"}, rdata, e);
                end
            end
            @(posedge HCLK); #1;
            if (adv) begin
                dph = aph; dph_v = aph_v; aph_v = 1'b0;
                if (txq.size() > 0) begin
                    aph = txq.pop_front(); aph_v = 1'b1;
                    if (!aph.wr) sbq.push_back(aph.data);
                end
                drive_addr(aph_v, aph);
                HWDATA = (dph_v && dph.wr) ? dph.data : 32'h0;
            end
        end
        if (guard >= 1000) begin
            total++;
            $display("FAIL %s timeout: HREADY stuck, got %0d cycles, expected completion", tag, guard);
        end
        chk({tag, " wait cycles"}, 32'(lows), 32'(nt * ws));
        chk({tag, " acccount"}, acc, 32'(acc_exp));
    endtask

    // One erroring write beat with junk data; expects (0,1), (1,1), then idle.
    task automatic err_tx(input logic [31:0] a, input logic [2:0] sz, input string tag);
        vec_t t;
        t = '{1'b1, a, sz, 32'h0};
        HWDATA = 32'hFFFF_FFFF;
        drive_addr(1'b1, t);
        @(posedge HCLK); #1;
        drive_addr(1'b0, t);
        @(negedge HCLK); chk({tag, " err1"}, {30'b0, rdy, resp}, 32'h1);
        @(negedge HCLK); chk({tag, " err2"}, {30'b0, rdy, resp}, 32'h3);
        @(negedge HCLK); chk({tag, " idle"}, {30'b0, rdy, resp}, 32'h2);
        @(posedge HCLK); #1;
        HWDATA = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t t;
        HRESETn = 1'b0; HBURST = 3'd0; HSEL = 1'b0; HTRANS = 2'b00;
        HADDR = 32'h0; HSIZE = 3'd0; HWRITE = 1'b0; HWDATA = 32'h0;
        dsel = 1'b0;

        tbl[0]  = '{1'b1, 32'h0000_0010, 3'd2, 32'hDEAD_BEEF};
        tbl[1]  = '{1'b0, 32'h0000_0010, 3'd2, 32'hDEAD_BEEF};
        tbl[2]  = '{1'b1, 32'h0000_0020, 3'd2, 32'h0000_0000};
        tbl[3]  = '{1'b1, 32'h0000_0021, 3'd0, 32'h0000_AA00};
        tbl[4]  = '{1'b1, 32'h0000_0022, 3'd1, 32'h1234_0000};
        tbl[5]  = '{1'b0, 32'h0000_0020, 3'd2, 32'h1234_AA00};
        tbl[6]  = '{1'b1, 32'h0000_1000, 3'd2, 32'h0000_0005};
        tbl[7]  = '{1'b0, 32'h0000_0000, 3'd2, 32'h0000_0005};
        tbl[8]  = '{1'b0, 32'h0000_0010, 3'd2, 32'hDEAD_BEEF};
        tbl[9]  = '{1'b1, 32'h0000_0013, 3'd0, 32'hFF00_0000};
        tbl[10] = '{1'b0, 32'h0000_0010, 3'd2, 32'hFFAD_BEEF};
        tbl[11] = '{1'b1, 32'h0000_0020, 3'd1, 32'h5555_CAFE};
        tbl[12] = '{1'b0, 32'h0000_0020, 3'd2, 32'h1234_CAFE};
        tbl[13] = '{1'b0, 32'h0000_0022, 3'd0, 32'h1234_CAFE};

        // Reset values on both instances.
        do_reset(3);
        @(negedge HCLK);
        chk("rst ws0 hready", 32'(rdy0), 32'h1);
        chk("rst ws0 hresp", 32'(resp0), 32'h0);
        chk("rst ws0 hrdata", rdata0, 32'h0);
        chk("rst ws0 acccount", acc0, 32'h0);
        chk("rst ws3 hready", 32'(rdy3), 32'h1);
        chk("rst ws3 hresp", 32'(resp3), 32'h0);
        chk("rst ws3 hrdata", rdata3, 32'h0);
        chk("rst ws3 acccount", acc3, 32'h0);
        @(posedge HCLK); #1;

        // Zero-wait round trip, then the rest of the table back-to-back.
        dsel = 1'b0;
        for (int i = 0; i < 2; i++) txq.push_back(tbl[i]);
        run_seq(0, "roundtrip");
        for (int i = 2; i < 14; i++) txq.push_back(tbl[i]);
        run_seq(0, "table");

        // Error responses leave memory and ACCCOUNT untouched.
        err_tx(32'h0000_0002, 3'd2, "err word misaligned");
        err_tx(32'h0000_0000, 3'd3, "err size3");
        err_tx(32'h0000_0001, 3'd1, "err half misaligned");
        chk("err acccount", acc, 32'(acc_exp));
        txq.push_back('{1'b0, 32'h0000_0000, 3'd2, 32'h0000_0005});
        run_seq(0, "after err");

        // Three wait states.
        dsel = 1'b1;
        do_reset(2);
        txq.push_back('{1'b1, 32'h0000_0040, 3'd2, 32'h1122_3344});
        txq.push_back('{1'b0, 32'h0000_0040, 3'd2, 32'h1122_3344});
        txq.push_back('{1'b0, 32'h0000_0041, 3'd0, 32'h1122_3344});
        run_seq(3, "ws3 burst");
        txq.push_back('{1'b0, 32'h0000_0040, 3'd2, 32'h1122_3344});
        run_seq(3, "ws3 single");

        // HWDATA during WAIT is junk; only the DATA-cycle value may land.
        t = '{1'b1, 32'h0000_0044, 3'd2, 32'h0};
        drive_addr(1'b1, t);
        HWDATA = 32'hBAD0_BAD0;
        @(posedge HCLK); #1;
        drive_addr(1'b0, t);
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            chk("ws3 wait low", 32'(rdy), 32'h0);
        end
        @(negedge HCLK);
        chk("ws3 data high", 32'(rdy), 32'h1);
        HWDATA = 32'h600D_F00D;
        @(posedge HCLK); #1;
        HWDATA = 32'hBAD0_BAD0;
        acc_exp++;
        txq.push_back('{1'b0, 32'h0000_0044, 3'd2, 32'h600D_F00D});
        run_seq(3, "ws3 hwdata");

        // Reset during a write's WAIT cycle discards the write.
        txq.push_back('{1'b1, 32'h0000_0048, 3'd2, 32'h1357_2468});
        run_seq(3, "ws3 pre");
        t = '{1'b1, 32'h0000_0048, 3'd2, 32'h0};
        drive_addr(1'b1, t);
        HWDATA = 32'hFFFF_FFFF;
        @(posedge HCLK); #1;
        drive_addr(1'b0, t);
        @(negedge HCLK);
        chk("midrst wait", 32'(rdy), 32'h0);
        HRESETn = 1'b0;
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        acc_exp = 0;
        @(negedge HCLK);
        chk("midrst hready", 32'(rdy), 32'h1);
        chk("midrst hresp", 32'(resp), 32'h0);
        chk("midrst hrdata", rdata, 32'h0);
        chk("midrst acccount", acc, 32'h0);
        repeat (5) @(posedge HCLK);
        #1;
        HWDATA = 32'h0;
        txq.push_back('{1'b0, 32'h0000_0048, 3'd2, 32'h1357_2468});
        run_seq(3, "midrst readback");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
